fixed_att_score_mask: RTL and testbench

Streaming scale-and-mask stage for attention score tiles, placed between the Q·Kᵀ matmul and the softmax. It accepts square score tiles of `PARALLELISM x PARALLELISM` elements in block-row-major order and tracks tile position and head index with internal counters. Each element is scaled by an arithmetic right shift with round-half-up and saturation. When enabled, a causal mask forces elements above the diagonal to the most negative value. Row-end and head-end tags are attached to each output tile so the downstream softmax can delimit rows.

---
 rtl/fixed_att_pkg.sv | 24 ++
 rtl/fixed_att_elem_scale.sv | 48 ++++
 rtl/fixed_att_score_mask.sv | 119 +++++++++++
 tb/tb_fixed_att_score_mask.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fixed_att_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fixed_att_pkg
// Brief   : Shared helpers for the attention score scale-and-mask stage.
// Revision: 1.0 - initial release
// ============================================================================
package fixed_att_pkg;

    // Number of bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Most negative two's complement value representable in 'width' bits.
    function automatic int most_neg(input int width);
        return -(1 << (width - 1));
    endfunction

    // Counter widths for the default geometry (NB = 2, NUM_HEADS = 2).
    localparam int DEFAULT_BLK_CNT_W  = cnt_width(2);
    localparam int DEFAULT_HEAD_CNT_W = cnt_width(2);

endpackage
`default_nettype wire

// File: rtl/fixed_att_elem_scale.sv
`default_nettype none
// ============================================================================
// Module  : fixed_att_elem_scale
// Brief   : Combinational arithmetic right shift with round-half-up and
//           saturation for one signed element.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_att_elem_scale #(
    parameter int DATA_WIDTH  = 8,
    parameter int SCALE_SHIFT = 1
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    generate
        if (SCALE_SHIFT == 0) begin : g_pass
            assign y = x;
        end else begin : g_shift
            // Half of one output LSB, added before truncation.
            localparam logic signed [DATA_WIDTH:0] ROUND   =
                (DATA_WIDTH + 1)'(1) << (SCALE_SHIFT - 1);
            localparam logic signed [DATA_WIDTH:0] SAT_MAX =
                {2'b00, {(DATA_WIDTH - 1){1'b1}}};
            localparam logic signed [DATA_WIDTH:0] SAT_MIN =
                {2'b11, {(DATA_WIDTH - 1){1'b0}}};

            logic signed [DATA_WIDTH:0] sum;
            logic signed [DATA_WIDTH:0] shifted;

            // One guard bit keeps x + ROUND from overflowing.
            assign sum     = {x[DATA_WIDTH-1], x} + ROUND;
            assign shifted = sum >>> SCALE_SHIFT;

            // Clamp the shifted value back into the output range.
            always_comb begin
                y = shifted[DATA_WIDTH-1:0];
                if (shifted > SAT_MAX) begin
                    y = SAT_MAX[DATA_WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    y = SAT_MIN[DATA_WIDTH-1:0];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fixed_att_score_mask.sv
`default_nettype none
// ============================================================================
// Module  : fixed_att_score_mask
// Brief   : Streaming scale and causal-mask stage for P x P attention score
//           tiles, with row-end / head-end tags for the downstream softmax.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_att_score_mask
    import fixed_att_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARALLELISM = 2,
    parameter int NUM_BLOCKS  = 2,
    parameter int NUM_HEADS   = 2,
    parameter int SCALE_SHIFT = 1,
    parameter int HAS_MASK    = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [PARALLELISM*PARALLELISM-1:0][DATA_WIDTH-1:0]   data_in,
    input  logic                                                 data_in_valid,
    output logic                                                 data_in_ready,
    output logic [PARALLELISM*PARALLELISM-1:0][DATA_WIDTH-1:0]   data_out,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready,
    output logic                                                 data_out_row_last,
    output logic                                                 data_out_head_last
);

    localparam int NUM_ELEMS = PARALLELISM * PARALLELISM;
    localparam int BLK_W     = cnt_width(NUM_BLOCKS);
    localparam int HEAD_W    = cnt_width(NUM_HEADS);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = DATA_WIDTH'(most_neg(DATA_WIDTH));
    localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [HEAD_W-1:0]     HEAD_LAST = HEAD_W'(NUM_HEADS - 1);

    logic [BLK_W-1:0]  col_cnt;
    logic [BLK_W-1:0]  row_cnt;
    logic [HEAD_W-1:0] head_cnt;
    logic              accept;
    logic              col_wrap;
    logic              row_wrap;

    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] next_data;

    assign data_in_ready = !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;
    assign col_wrap      = (col_cnt == BLK_LAST);
    assign row_wrap      = (row_cnt == BLK_LAST);

    // Per-element scaling and causal masking against global row/column.
    genvar gi, gj;
    generate
        for (gi = 0; gi < PARALLELISM; gi++) begin : g_row
            for (gj = 0; gj < PARALLELISM; gj++) begin : g_col
                localparam int IDX = gi * PARALLELISM + gj;

                logic [DATA_WIDTH-1:0] scaled;
                logic                  masked;

                fixed_att_elem_scale #(
                    .DATA_WIDTH  (DATA_WIDTH),
                    .SCALE_SHIFT (SCALE_SHIFT)
                ) u_scale (
                    .x (data_in[IDX]),
                    .y (scaled)
                );

                // Element lies strictly above the diagonal of the full matrix.
                always_comb begin
                    masked = 1'b0;
                    if (HAS_MASK != 0) begin
                        masked = (int'(col_cnt) * PARALLELISM + gj) >
                                 (int'(row_cnt) * PARALLELISM + gi);
                    end
                end

                assign next_data[IDX] = masked ? MOST_NEG : scaled;
            end
        end
    endgenerate

    // Tile position counters advance on each accepted input tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            head_cnt <= '0;
        end else if (accept) begin
            col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
            if (col_wrap) begin
                row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
                if (row_wrap) begin
                    head_cnt <= (head_cnt == HEAD_LAST) ? '0 : head_cnt + 1'b1;
                end
            end
        end
    end

    // Single output register stage holding data, tags and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out           <= '0;
            data_out_valid     <= 1'b0;
            data_out_row_last  <= 1'b0;
            data_out_head_last <= 1'b0;
        end else if (accept) begin
            data_out           <= next_data;
            data_out_valid     <= 1'b1;
            data_out_row_last  <= col_wrap;
            data_out_head_last <= col_wrap && row_wrap;
        end else if (data_out_ready) begin
            data_out_valid     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_att_score_mask.sv
`default_nettype none
// ============================================================================
// Module  : tb_fixed_att_score_mask
// Brief   : Directed self-checking bench for fixed_att_score_mask.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fixed_att_score_mask;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0][7:0] din = '0;
    logic        vin = 1'b0;
    logic        oready = 1'b1;

    logic            iready, ovalid, row_last, head_last;
    logic [3:0][7:0] dout;
    logic            p_iready, p_ovalid, p_row_last, p_head_last;
    logic [3:0][7:0] p_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_att_score_mask #(
        .DATA_WIDTH(8), .PARALLELISM(2), .NUM_BLOCKS(2),
        .NUM_HEADS(2), .SCALE_SHIFT(1), .HAS_MASK(1)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(vin), .data_in_ready(iready),
        .data_out(dout), .data_out_valid(ovalid), .data_out_ready(oready),
        .data_out_row_last(row_last), .data_out_head_last(head_last)
    );

    fixed_att_score_mask #(
        .DATA_WIDTH(8), .PARALLELISM(2), .NUM_BLOCKS(2),
        .NUM_HEADS(2), .SCALE_SHIFT(0), .HAS_MASK(0)
    ) dut_pass (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(vin), .data_in_ready(p_iready),
        .data_out(p_dout), .data_out_valid(p_ovalid), .data_out_ready(oready),
        .data_out_row_last(p_row_last), .data_out_head_last(p_head_last)
    );

    function automatic logic [31:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a tile and let one rising edge transfer it; returns #1 after the edge.
    task automatic send(input logic [31:0] t);
        @(negedge clk);
        din    = t;
        vin    = 1'b1;
        oready = 1'b1;
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1. Reset state
        do_reset();
        chk("rst_valid",     {31'd0, ovalid},    32'd0);
        chk("rst_row_last",  {31'd0, row_last},  32'd0);
        chk("rst_head_last", {31'd0, head_last}, 32'd0);
        chk("rst_ready",     {31'd0, iready},    32'd1);
        chk("rst_data",      dout,               32'd0);

        // 2. Tile (r0,c0), all 6, with latency check
        @(negedge clk);
        din = pk(8'd6, 8'd6, 8'd6, 8'd6);
        vin = 1'b1;
        #1;
        chk("lat_before_edge", {31'd0, ovalid}, 32'd0);
        @(posedge clk);
        #1;
        vin = 1'b0;
        chk("a_valid",    {31'd0, ovalid},   32'd1);
        chk("a_data",     dout,              pk(8'd3, 8'h80, 8'd3, 8'd3));
        chk("a_row_last", {31'd0, row_last}, 32'd0);
        chk("a_pass",     p_dout,            pk(8'd6, 8'd6, 8'd6, 8'd6));

        // 3. Tile (r0,c1), fully above the diagonal
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        chk("b_data",      dout,               pk(8'h80, 8'h80, 8'h80, 8'h80));
        chk("b_row_last",  {31'd0, row_last},  32'd1);
        chk("b_head_last", {31'd0, head_last}, 32'd0);

        // 4. Tile (r1,c0): fully unmasked, rounding and negative values
        send(pk(8'd127, 8'hFD, 8'h80, 8'd5));
        chk("c_data",      dout,   pk(8'd64, 8'hFF, 8'hC0, 8'd3));
        chk("c_row_last",  {31'd0, row_last}, 32'd0);
        chk("c_pass",      p_dout, pk(8'd127, 8'hFD, 8'h80, 8'd5));

        // Tile (r1,c1): diagonal tile, end of head
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        chk("d_data",      dout,               pk(8'd3, 8'h80, 8'd3, 8'd3));
        chk("d_row_last",  {31'd0, row_last},  32'd1);
        chk("d_head_last", {31'd0, head_last}, 32'd1);
        chk("d_pass_head", {31'd0, p_head_last}, 32'd1);

        // 5. Head 1, tile (r0,c0)
        send(pk(8'd10, 8'd10, 8'd10, 8'd10));
        chk("t5_data", dout, pk(8'd5, 8'h80, 8'd5, 8'd5));

        // Backpressure for 3 cycles with the next tile pending
        @(negedge clk);
        oready = 1'b0;
        din    = pk(8'd20, 8'd20, 8'd20, 8'd20);
        vin    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_ready",     {31'd0, iready},    32'd0);
            chk("bp_valid",     {31'd0, ovalid},    32'd1);
            chk("bp_data",      dout,               pk(8'd5, 8'h80, 8'd5, 8'd5));
            chk("bp_row_last",  {31'd0, row_last},  32'd0);
            chk("bp_head_last", {31'd0, head_last}, 32'd0);
        end

        // Release: both handshakes each cycle, one tile per cycle
        @(negedge clk);
        oready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_data",     dout,              pk(8'h80, 8'h80, 8'h80, 8'h80));
        chk("t6_row_last", {31'd0, row_last}, 32'd1);
        chk("t6_ready",    {31'd0, iready},   32'd1);
        din = pk(8'd20, 8'd20, 8'd20, 8'd20);
        @(posedge clk);
        #1;
        chk("t7_data",     dout,              pk(8'd10, 8'd10, 8'd10, 8'd10));
        chk("t7_row_last", {31'd0, row_last}, 32'd0);
        din = pk(8'd40, 8'd40, 8'd40, 8'd40);
        @(posedge clk);
        #1;
        vin = 1'b0;
        chk("t8_data",      dout,               pk(8'd20, 8'h80, 8'd20, 8'd20));
        chk("t8_head_last", {31'd0, head_last}, 32'd1);

        // 6. Wrap: ninth tile is (r0,c0) of head 0
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        chk("t9_data",      dout,               pk(8'd3, 8'h80, 8'd3, 8'd3));
        chk("t9_row_last",  {31'd0, row_last},  32'd0);
        chk("t9_head_last", {31'd0, head_last}, 32'd0);
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        chk("t10_data", dout, pk(8'h80, 8'h80, 8'h80, 8'h80));

        // Idle cycle drains the output register
        @(posedge clk);
        #1;
        chk("idle_valid", {31'd0, ovalid}, 32'd0);

        // Mid-head reset: next tile restarts at (r0,c0)
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        do_reset();
        chk("rst2_valid", {31'd0, ovalid}, 32'd0);
        chk("rst2_data",  dout,            32'd0);
        chk("rst2_ready", {31'd0, iready}, 32'd1);
        send(pk(8'd6, 8'd6, 8'd6, 8'd6));
        chk("post_rst_data",     dout,              pk(8'd3, 8'h80, 8'd3, 8'd3));
        chk("post_rst_row_last", {31'd0, row_last}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
